// File: rtl/scanner_lot_sequencer.sv
// Lot-level scheduler for the lithography scanner: issues one start per wafer,
// follows the scanner step code back to IDLE, and fails the lot on error, watchdog or abort.
module scanner_lot_sequencer #(
  parameter int STEP_TIMEOUT = 1000,
  parameter int LOT_W        = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lot_start,
  input  logic [LOT_W-1:0] lot_size,
  input  logic             abort,
  input  logic [3:0]       scan_step,
  output logic             start_cmd,
  output logic             scan_reset,
  output logic             busy,
  output logic [LOT_W-1:0] wafer_cnt,
  output logic             lot_done,
  output logic             lot_fail,
  output logic             timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_RUN,
    S_RUN,
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [3:0]  STEP_IDLE = 4'd0;
  localparam logic [3:0]  STEP_ERR  = 4'd15;
  localparam logic [15:0] WD_LIMIT  = 16'(STEP_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [LOT_W-1:0] target_q, target_d;
  logic [LOT_W-1:0] wafer_cnt_q, wafer_cnt_d;
  logic             lot_fail_q, lot_fail_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      wd_q, wd_d;
  logic [3:0]       prev_step_q, prev_step_d;

  logic step_changed;
  logic wd_expired;
  logic fail_go;
  logic timeout_go;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    wafer_cnt_d = wafer_cnt_q;
    lot_fail_d  = lot_fail_q;
    timeout_d   = timeout_q;
    wd_d        = '0;
    prev_step_d = scan_step;
    fail_go     = 1'b0;
    timeout_go  = 1'b0;

    step_changed = (scan_step != prev_step_q);
    wd_expired   = !step_changed && (wd_q == WD_LIMIT);

    case (state_q)
      S_IDLE: begin
        if (lot_start && (lot_size != '0)) begin
          target_d    = lot_size;
          wafer_cnt_d = '0;
          lot_fail_d  = 1'b0;
          timeout_d   = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT_RUN;
      end
      S_WAIT_RUN: begin
        wd_d = step_changed ? 16'd0 : wd_q + 16'd1;
        if (scan_step == STEP_ERR) begin
          fail_go = 1'b1;
        end else if (scan_step != STEP_IDLE) begin
          state_d = S_RUN;
        end else if (wd_expired) begin
          fail_go    = 1'b1;
          timeout_go = 1'b1;
        end
      end
      S_RUN: begin
        wd_d = step_changed ? 16'd0 : wd_q + 16'd1;
        if (scan_step == STEP_ERR) begin
          fail_go = 1'b1;
        end else if (scan_step == STEP_IDLE) begin
          // Saturate at target so a stray extra completion can never wrap the count.
          if (wafer_cnt_q != target_q) begin
            wafer_cnt_d = wafer_cnt_q + 1'b1;
          end
          state_d = S_NEXT;
        end else if (wd_expired) begin
          fail_go    = 1'b1;
          timeout_go = 1'b1;
        end
      end
      S_NEXT: begin
        state_d = (wafer_cnt_q == target_q) ? S_DONE : S_START;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAIL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort outranks every in-lot cause and is never a watchdog failure.
    if (abort && (state_q != S_IDLE) && (state_q != S_FAIL)) begin
      fail_go    = 1'b1;
      timeout_go = 1'b0;
    end

    if (fail_go) begin
      state_d    = S_FAIL;
      lot_fail_d = 1'b1;
      timeout_d  = timeout_go;
      wd_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      wafer_cnt_q <= '0;
      lot_fail_q  <= 1'b0;
      timeout_q   <= 1'b0;
      wd_q        <= '0;
      prev_step_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      wafer_cnt_q <= wafer_cnt_d;
      lot_fail_q  <= lot_fail_d;
      timeout_q   <= timeout_d;
      wd_q        <= wd_d;
      prev_step_q <= prev_step_d;
    end
  end

  assign start_cmd    = (state_q == S_START);
  assign scan_reset   = (state_q == S_FAIL);
  assign lot_done     = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign wafer_cnt    = wafer_cnt_q;
  assign lot_fail     = lot_fail_q;
  assign timeout_flag = timeout_q;

endmodule

// File: doc/scanner_lot_sequencer.md
# scanner_lot_sequencer

Lot-level scheduler for the lithography scanner sequence controller. It takes a lot request of N wafers and issues one `start_cmd` per wafer. It tracks each wafer through the scanner's step code (`current_step`) until it returns to IDLE, counts completed wafers, and runs a per-step watchdog. On a scanner error, a watchdog timeout or an operator abort, it pulses a scanner reset and flags the lot as failed. It sits between the host/equipment command layer and the scanner FSM.

## Interface
Parameters:
- `STEP_TIMEOUT`, 1000 — maximum consecutive cycles `scan_step` may hold one non-error value before timeout; legal range 2..65535.
- `LOT_W`, 5 — width of the wafer count fields (lot of up to 2^LOT_W−1 wafers).

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `reset`  in  1  — reset is synchronous and active-high.
- `lot_start`  in  1  — one-cycle lot request; honoured only in IDLE.
- `lot_size`  in  LOT_W  — wafers in lot; sampled with `lot_start`.
- `abort`  in  1  — operator abort; level, sampled every cycle.
- `scan_step`  in  4  — scanner `current_step` (0 = IDLE, 15 = ERROR).
- `start_cmd`  out  1  — one-cycle start pulse to scanner.
- `scan_reset`  out  1  — one-cycle recovery pulse to scanner reset.
- `busy`  out  1  — high in every state except IDLE.
- `wafer_cnt`  out  LOT_W  — wafers completed in current/last lot.
- `lot_done`  out  1  — one-cycle pulse on successful lot completion.
- `lot_fail`  out  1  — level; set on failure, cleared by next accepted `lot_start` or `reset`.
- `timeout_flag`  out  1  — level; set when the failure cause is the watchdog; cleared with `lot_fail`.

## Operation
- States: IDLE, START, WAIT_RUN, RUN, NEXT, DONE, FAIL.
- IDLE: on `lot_start` with `lot_size` ≠ 0:
  - latch `target` <= `lot_size`; `wafer_cnt` <= 0; clear `lot_fail` and `timeout_flag`;
  - go to START.
  - `lot_start` with `lot_size` = 0 is ignored: no state change, flags untouched.
- START: `start_cmd` = 1 for exactly this cycle → WAIT_RUN.
- WAIT_RUN: wait for `scan_step` ≠ 0 (scanner left IDLE). If `scan_step` = 15 → FAIL; else if ≠ 0 → RUN.
- RUN:
  - `scan_step` = 15 → FAIL.
  - `scan_step` = 0 → wafer complete; `wafer_cnt` +1 → NEXT.
- NEXT: `wafer_cnt` = `target` → DONE, else → START.
- DONE: `lot_done` = 1 for one cycle → IDLE.
- FAIL: `scan_reset` = 1 for one cycle; `lot_fail` <= 1 → IDLE. `wafer_cnt` holds the number of completed wafers.
- Watchdog (active in WAIT_RUN and RUN):
  - counter `wd` cleared on entry to WAIT_RUN and in any cycle where `scan_step` differs from its previous-cycle value; otherwise `wd` +1.
  - When `wd` = STEP_TIMEOUT−1 and `scan_step` is unchanged → FAIL with `timeout_flag` <= 1.
- Abort: `abort` = 1 in any state other than IDLE/FAIL → FAIL next cycle (`timeout_flag` stays 0). Ignored in IDLE.
- Priority in one cycle: `reset` > `abort` > `scan_step` = 15 > wafer-complete > watchdog. An error and a timeout in the same cycle give FAIL with `timeout_flag` = 0.
- `lot_start` while `busy` is ignored; `target` is not re-latched.
- `wafer_cnt` never exceeds `target`; no wrap.

## Timing
- Reset values: state IDLE, `start_cmd` 0, `scan_reset` 0, `busy` 0, `wafer_cnt` 0, `lot_done` 0, `lot_fail` 0, `timeout_flag` 0, `wd` 0.
- Reset mid-lot returns to IDLE next edge. No `scan_reset` pulse is issued; the scanner shares the system reset.
- All outputs are registered or decoded from the state register; there is no combinational input→output path.
- `lot_start` accepted at edge k → `start_cmd` high in cycle k+1, `busy` high from k+1.
- Final wafer seen at `scan_step` = 0 in RUN at edge m → NEXT at m+1, DONE at m+2 (`lot_done` high), IDLE at m+3.
- Inter-wafer gap: NEXT → START adds 2 cycles between wafer completion and the next `start_cmd`.
- Error/abort seen at edge e → `scan_reset` and `lot_fail` high in cycle e+1; `busy` low from e+2.

## Test plan
- Normal lot: `lot_size` = 3, scanner model completes each wafer in 40 cycles → three `start_cmd` pulses, `wafer_cnt` 1,2,3, single `lot_done`, `lot_fail` = 0.
- Scanner error: `lot_size` = 4, `scan_step` = 15 during wafer 2 → `scan_reset` pulse, `lot_fail` = 1, `timeout_flag` = 0, `wafer_cnt` = 1, no `lot_done`.
- Watchdog: STEP_TIMEOUT = 8, `scan_step` stuck at 6 → FAIL exactly on the 8th unchanged cycle, `timeout_flag` = 1. The same stimulus with a step change at cycle 7 produces no timeout.
- Abort: `abort` during WAIT_RUN and during RUN → FAIL next cycle, `scan_reset` pulse. `abort` in IDLE → no effect.
- Request filtering: `lot_start` with `lot_size` = 0 → stays IDLE. `lot_start` with `lot_size` = 5 while busy with a 2-wafer lot → ignored; lot ends with `wafer_cnt` = 2.
- Reset mid-lot in RUN → all outputs at reset values next cycle; a new lot of 1 then completes normally.
